// File: rtl/prach_pkg.sv
// prach_pkg: shared state encoding and default widths for the PRACH buffer stages
// No ports. Provides cp_state_e and the default CP/sequence counter widths.
package prach_pkg;
  typedef enum logic [1:0] {IDLE, CP, SEQ} cp_state_e;
  localparam int CP_W_DEF  = 14;
  localparam int SEQ_W_DEF = 16;
  localparam int WIDTH_DEF = 144;
endpackage

// File: rtl/prach_buffer_out_reg.sv
// prach_buffer_out_reg: 1-deep valid/ready pipeline register
// Ports: clk, rst_n (async active-low); in_valid/in_data/in_ready upstream side;
//        out_valid/out_data/out_ready downstream side.
module prach_buffer_out_reg #(
  parameter int W = 145
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  // Ready whenever the slot is empty or draining this cycle, so a drain and a
  // reload can share one cycle.
  assign in_ready = ~out_valid | out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      out_data  <= in_valid ? in_data : out_data;
    end
  end
endmodule

// File: rtl/prach_buffer_cp_remove.sv
// prach_buffer_cp_remove: strip cyclic prefix and inter-occasion beats from the PRACH sample stream
// Ports: clk, rst_n (async active-low); cfg_cp_len/cfg_seq_len latched on accepted sop;
//        s_valid/s_data/s_sop/s_ready input stream; m_valid/m_data/m_last/m_ready to FIFO;
//        busy (in CP or SEQ), err_trunc (sop before occasion completed), err_cnt.
// Build option: define PRACH_CP_ERR_CNT_EN for a saturating truncation counter on err_cnt;
//               otherwise err_cnt is tied to zero.
module prach_buffer_cp_remove
  import prach_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CP_W  = CP_W_DEF,
  parameter int SEQ_W = SEQ_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CP_W-1:0]  cfg_cp_len,
  input  logic [SEQ_W-1:0] cfg_seq_len,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_sop,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic             err_trunc,
  output logic [15:0]      err_cnt
);
  cp_state_e        state;
  logic [CP_W-1:0]  cp_rem;
  logic [SEQ_W-1:0] seq_rem;
  logic             out_rdy, acc, sop_acc, trunc, fwd, fwd_last;
  // A sop with zero CP forwards immediately, so it needs the output slot too.
  assign s_ready  = out_rdy | ~(state == SEQ | (s_sop & cfg_cp_len == '0));
  assign acc      = s_valid & s_ready;
  assign sop_acc  = acc & s_sop;
  assign trunc    = sop_acc & state != IDLE;
  assign fwd      = sop_acc ? (cfg_cp_len == '0 & cfg_seq_len != '0) : acc & state == SEQ;
  assign fwd_last = s_sop ? cfg_seq_len == SEQ_W'(1) : seq_rem == SEQ_W'(1);
  assign busy     = state != IDLE;
  // cp_rem counts CP beats still to drop; seq_rem counts sequence beats still to forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cp_rem    <= '0;
      seq_rem   <= '0;
      err_trunc <= 1'b0;
    end else begin
      err_trunc <= trunc;
      if (sop_acc) begin
        if (cfg_cp_len != '0) begin
          cp_rem  <= cfg_cp_len - CP_W'(1);
          seq_rem <= cfg_seq_len;
          state   <= cfg_cp_len != CP_W'(1) ? CP : (cfg_seq_len != '0 ? SEQ : IDLE);
        end else begin
          cp_rem  <= '0;
          seq_rem <= cfg_seq_len == '0 ? '0 : cfg_seq_len - SEQ_W'(1);
          state   <= cfg_seq_len > SEQ_W'(1) ? SEQ : IDLE;
        end
      end else if (acc & state == CP) begin
        cp_rem <= cp_rem - CP_W'(1);
        if (cp_rem == CP_W'(1)) state <= seq_rem != '0 ? SEQ : IDLE;
      end else if (acc & state == SEQ) begin
        seq_rem <= seq_rem - SEQ_W'(1);
        if (seq_rem == SEQ_W'(1)) state <= IDLE;
      end
    end
  end
`ifdef PRACH_CP_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= '0;
    else if (trunc & err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`else
  assign err_cnt = '0;
`endif
  prach_buffer_out_reg #(.W(WIDTH + 1)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (fwd),
    .in_data   ({fwd_last, s_data}),
    .in_ready  (out_rdy),
    .out_valid (m_valid),
    .out_data  ({m_last, m_data}),
    .out_ready (m_ready)
  );
endmodule

// File: tb/tb_prach_buffer_cp_remove.sv
// tb_prach_buffer_cp_remove: directed and randomized checks against an occasion-position model
module tb_prach_buffer_cp_remove;
  localparam int WIDTH = 144;
  logic             clk = 0, rst_n = 0;
  logic [13:0]      cfg_cp_len = '0;
  logic [15:0]      cfg_seq_len = '0;
  logic             s_valid = 0, s_sop = 0, s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             m_valid, m_last, m_ready = 1;
  logic [WIDTH-1:0] m_data;
  logic             busy, err_trunc;
  logic [15:0]      err_cnt;
  int checks = 0, errors = 0;
  int rmode = 0;
  logic [WIDTH:0] exp_q[$];
  bit   active = 0;
  int   pos = 0, lcp = 0, lseq = 0, tr_tot = 0, tr_rst = 0, trunc_seen = 0;
  bit   prev_stall = 0;
  logic [WIDTH-1:0] prev_data;
  logic prev_last;
  logic [WIDTH:0] e;

  prach_buffer_cp_remove dut (
    .clk(clk), .rst_n(rst_n), .cfg_cp_len(cfg_cp_len), .cfg_seq_len(cfg_seq_len),
    .s_valid(s_valid), .s_data(s_data), .s_sop(s_sop), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .err_trunc(err_trunc), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ecnt_exp();
`ifdef PRACH_CP_ERR_CNT_EN
    return tr_rst > 65535 ? 16'hFFFF : 16'(tr_rst);
`else
    return 16'd0;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    if (rmode == 0) m_ready = 1;
    else if (rmode == 1) m_ready = ~m_ready;
    else m_ready = $urandom_range(0, 2) != 0;
  end

  // Model: each occasion is a run of cp+seq beats counted from the accepted sop;
  // positions cp..cp+seq-1 are forwarded in order, the final one carrying last.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      active = 0; pos = 0; tr_rst = 0; prev_stall = 0;
    end else begin
      chk("s_ready", s_ready, !(m_valid && !m_ready && ((active && pos >= lcp) || (s_sop && cfg_cp_len == 0))));
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
        chk("hold_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", m_data, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", m_data, e[WIDTH-1:0]);
          chk("out_last", m_last, e[WIDTH]);
        end
      end
      if (s_valid && s_ready) begin
        if (s_sop) begin
          if (active) begin tr_tot++; tr_rst++; end
          lcp = int'(cfg_cp_len); lseq = int'(cfg_seq_len); pos = 0;
          active = (lcp + lseq) > 0;
        end
        if (active) begin
          if (pos >= lcp) exp_q.push_back({pos == lcp + lseq - 1, s_data});
          pos++;
          if (pos >= lcp + lseq) active = 0;
        end
      end
      if (err_trunc) trunc_seen++;
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic send(input logic sop, input logic [WIDTH-1:0] d);
    bit ok = 0;
    s_valid = 1; s_sop = sop; s_data = d;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = s_ready;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 0; s_sop = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_trunc", err_trunc, 0);
    chk("rst_err_cnt", err_cnt, 0);
    idle(2);
    rst_n = 1;
    idle(1);
    // 1: cp=4 seq=8 contiguous
    cfg_cp_len = 4; cfg_seq_len = 8;
    for (int i = 0; i < 12; i++) begin
      send(i == 0, WIDTH'(i));
      if (i == 0) chk("t1_busy", busy, 1);
      if (i == 3) chk("t1_no_early_out", m_valid, 0);
      if (i == 4) begin
        chk("t1_first_valid", m_valid, 1);
        chk("t1_first_data", m_data, 4);
      end
    end
    chk("t1_last", m_last, 1);
    idle(3);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_idle", busy, 0);
    // 2: cp=0 seq=3
    cfg_cp_len = 0; cfg_seq_len = 3;
    send(1, 'h100);
    chk("t2_sop_fwd", m_data, 'h100);
    chk("t2_sop_valid", m_valid, 1);
    send(0, 'h101);
    send(0, 'h102);
    chk("t2_last", m_last, 1);
    idle(3);
    chk("t2_drained", exp_q.size(), 0);
    // 3: stalled output
    rmode = 1;
    cfg_cp_len = 4; cfg_seq_len = 8;
    for (int i = 0; i < 12; i++) send(i == 0, WIDTH'('h200 + i));
    idle(6);
    chk("t3_drained", exp_q.size(), 0);
    rmode = 0;
    idle(2);
    // 4: truncation in SEQ
    for (int i = 0; i < 7; i++) send(i == 0, WIDTH'('h300 + i));
    send(1, 'h307);
    chk("t4_trunc_pulse", err_trunc, 1);
    chk("t4_err_cnt", err_cnt, ecnt_exp());
    send(0, 'h308);
    chk("t4_trunc_once", err_trunc, 0);
    for (int i = 9; i < 19; i++) send(0, WIDTH'('h300 + i));
    idle(3);
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_trunc_count", trunc_seen, 1);
    chk("t4_err_cnt_final", err_cnt, ecnt_exp());
    // 5: idle beats dropped, cfg changes after sop ignored
    for (int i = 0; i < 3; i++) send(0, WIDTH'('h400 + i));
    idle(2);
    chk("t5_idle_drop", m_valid, 0);
    cfg_cp_len = 2; cfg_seq_len = 3;
    send(1, 'h410);
    cfg_cp_len = 7; cfg_seq_len = 1;
    for (int i = 1; i < 5; i++) send(0, WIDTH'('h410 + i));
    chk("t5_latched_last", m_last, 1);
    chk("t5_latched_data", m_data, 'h414);
    idle(3);
    chk("t5_drained", exp_q.size(), 0);
    // 6: reset during SEQ
    cfg_cp_len = 1; cfg_seq_len = 10;
    for (int i = 0; i < 4; i++) send(i == 0, WIDTH'('h500 + i));
    chk("t6_pre_valid", m_valid, 1);
    rst_n = 0;
    #1;
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_busy", busy, 0);
    idle(2);
    rst_n = 1;
    for (int i = 0; i < 3; i++) send(0, WIDTH'('h600 + i));
    idle(2);
    chk("t6_ignore_valid", m_valid, 0);
    chk("t6_ignore_busy", busy, 0);
    // random phase
    rmode = 2;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        cfg_cp_len = 14'($urandom_range(0, 5));
        cfg_seq_len = 16'($urandom_range(0, 6));
      end
      send($urandom_range(0, 7) == 0, {$urandom, $urandom, $urandom, $urandom, 16'($urandom)});
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    rmode = 0;
    idle(10);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_trunc_count", trunc_seen, tr_tot);
    chk("rand_err_cnt", err_cnt, ecnt_exp());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
